// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, cause codes,
// mstatus/mie bit positions and the misa constant.
package csr_pkg;

  localparam logic [11:0] CsrMstatus       = 12'h300;
  localparam logic [11:0] CsrMisa          = 12'h301;
  localparam logic [11:0] CsrMie           = 12'h304;
  localparam logic [11:0] CsrMtvec         = 12'h305;
  localparam logic [11:0] CsrMcountinhibit = 12'h320;
  localparam logic [11:0] CsrMscratch      = 12'h340;
  localparam logic [11:0] CsrMepc          = 12'h341;
  localparam logic [11:0] CsrMcause        = 12'h342;
  localparam logic [11:0] CsrMtval         = 12'h343;
  localparam logic [11:0] CsrMip           = 12'h344;
  localparam logic [11:0] CsrMcycle        = 12'hB00;
  localparam logic [11:0] CsrMinstret      = 12'hB02;
  localparam logic [11:0] CsrMhpm3         = 12'hB03;
  localparam logic [11:0] CsrMcycleh       = 12'hB80;
  localparam logic [11:0] CsrMinstreth     = 12'hB82;
  localparam logic [11:0] CsrMhpm3h        = 12'hB83;

  localparam logic [4:0] ExcInstrMisaligned = 5'd0;
  localparam logic [4:0] ExcIllegalInstr    = 5'd2;
  localparam logic [4:0] ExcBreakpoint      = 5'd3;
  localparam logic [4:0] ExcEcallM          = 5'd11;
  localparam logic [4:0] IntMsi             = 5'd3;
  localparam logic [4:0] IntMti             = 5'd7;
  localparam logic [4:0] IntMei             = 5'd11;

  localparam int unsigned MstatusMie  = 3;
  localparam int unsigned MstatusMpie = 7;
  localparam int unsigned MstatusMpp  = 11;
  localparam int unsigned MieMsie     = 3;
  localparam int unsigned MieMtie     = 7;
  localparam int unsigned MieMeie     = 11;

  typedef enum logic [1:0] {TrapNone, TrapExc, TrapInt} trap_kind_e;

  // MXL in the top two bits, I and M extensions.
  function automatic logic [63:0] misa_value(input int unsigned xlen);
    if (xlen == 64) return 64'h8000_0000_0000_1100;
    return 64'h0000_0000_4000_1100;
  endfunction

  // Counter slot i -> CSR number offset (slot 1 is minstret, skipping time).
  function automatic int unsigned counter_csr_num(input int unsigned i);
    return (i == 0) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/csr_machine_if.sv
// Bus bundle between decode/execute and the machine CSR file.
interface csr_machine_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_HPM  = 4,
  parameter int unsigned RETIRE_W = 2
);
  localparam int unsigned HpmW = (NUM_HPM > 0) ? NUM_HPM : 1;

  logic                rden;
  logic [11:0]         raddr;
  logic [XLEN-1:0]     rdata;
  logic                illegal;
  logic                wren;
  logic [11:0]         waddr;
  logic [XLEN-1:0]     wdata;
  logic [RETIRE_W-1:0] retire;
  logic [HpmW-1:0]     hpm_event;
  logic                exc_valid;
  logic [4:0]          exc_cause;
  logic [XLEN-1:0]     exc_epc;
  logic [XLEN-1:0]     exc_tval;
  logic [XLEN-1:0]     int_epc;
  logic                int_ok;
  logic                mret_req;
  logic                meip;
  logic                mtip;
  logic                msip;
  logic                trap;
  logic                mret;
  logic [XLEN-1:0]     trap_vec;
  logic [XLEN-1:0]     mepc_out;

  modport slave (
    input  rden, raddr, wren, waddr, wdata, retire, hpm_event, exc_valid, exc_cause,
           exc_epc, exc_tval, int_epc, int_ok, mret_req, meip, mtip, msip,
    output rdata, illegal, trap, mret, trap_vec, mepc_out
  );

  modport master (
    output rden, raddr, wren, waddr, wdata, retire, hpm_event, exc_valid, exc_cause,
           exc_epc, exc_tval, int_epc, int_ok, mret_req, meip, mtip, msip,
    input  rdata, illegal, trap, mret, trap_vec, mepc_out
  );

endinterface

// File: rtl/csr_counter.sv
// 64-bit performance counter with inhibit, variable increment and lo/hi/full writes.
module csr_counter #(
  parameter int unsigned IncW = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inhibit,
  input  logic [IncW-1:0] i_inc,
  input  logic            i_wr_lo,
  input  logic            i_wr_hi,
  input  logic            i_wr_full,
  input  logic [63:0]     i_wdata,
  output logic [63:0]     o_value
);

  logic [63:0] r_value;

  // Any write suppresses this cycle's increment.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value <= '0;
    end else if (i_wr_full) begin
      r_value <= i_wdata;
    end else if (i_wr_lo || i_wr_hi) begin
      if (i_wr_lo) r_value[31:0]  <= i_wdata[31:0];
      if (i_wr_hi) r_value[63:32] <= i_wdata[31:0];
    end else if (!i_inhibit) begin
      r_value <= r_value + 64'(i_inc);
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/csr_machine.sv
// Parametrised machine-mode CSR file with counters, trap arbitration and mret.
// Build option: CSR_VECTORED_EN enables vectored mtvec mode for interrupts.
module csr_machine
  import csr_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_HPM  = 4,
  parameter int unsigned RETIRE_W = 2
) (
  input logic          i_clk,
  input logic          i_rst,
  csr_machine_if.slave bus
);

  localparam int unsigned NumCnt = NUM_HPM + 2;
  localparam int unsigned InhW   = NUM_HPM + 3;
  localparam logic [InhW-1:0] InhMask = ~(InhW'(2));

  logic             r_mie_g;
  logic             r_mpie;
  logic [2:0]       r_mie;  // {MEIE, MTIE, MSIE}
  logic [2:0]       r_mip;  // {MEIP, MTIP, MSIP}
  logic [XLEN-1:2]  r_mtvec_base;
`ifdef CSR_VECTORED_EN
  logic             r_mtvec_mode;
`endif
  logic [XLEN-1:0]  r_mscratch;
  logic [XLEN-1:0]  r_mepc;
  logic [XLEN-1:0]  r_mtval;
  logic             r_mcause_int;
  logic [4:0]       r_mcause_code;
  logic [InhW-1:0]  r_inhibit;
  logic             r_trap;
  logic             r_mret;
  logic [XLEN-1:0]  r_trap_vec;

  logic [63:0]      w_cnt [NumCnt];
  trap_kind_e       w_kind;
  logic [4:0]       w_code;
  logic             w_trap;
  logic             w_is_int;
  logic             w_do_mret;
  logic             w_int_en;
  logic [2:0]       w_pend;
  logic [XLEN-1:0]  w_vec;
  logic [XLEN-1:0]  w_mtvec_rd;
  logic [XLEN-1:0]  w_mstatus;
  logic [XLEN-1:0]  w_rdata;
  logic             w_hit;

  for (genvar gi = 0; gi < NumCnt; gi++) begin : g_cnt
    localparam int unsigned N = counter_csr_num(gi);
    logic [RETIRE_W-1:0] w_inc;
    logic                w_lo_hit;
    logic                w_hi_hit;

    if (gi == 0) begin : g_cycle
      assign w_inc = RETIRE_W'(1'b1);
    end else if (gi == 1) begin : g_instret
      assign w_inc = bus.retire;
    end else begin : g_hpm
      assign w_inc = RETIRE_W'(bus.hpm_event[gi-2]);
    end

    assign w_lo_hit = bus.wren && (bus.waddr == CsrMcycle + 12'(N));
    assign w_hi_hit = bus.wren && (bus.waddr == CsrMcycleh + 12'(N));

    csr_counter #(.IncW(RETIRE_W)) u_cnt (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_inhibit(r_inhibit[N]),
      .i_inc    (w_inc),
      .i_wr_lo  (w_lo_hit && (XLEN == 32)),
      .i_wr_hi  (w_hi_hit && (XLEN == 32)),
      .i_wr_full(w_lo_hit && (XLEN == 64)),
      .i_wdata  (64'(bus.wdata)),
      .o_value  (w_cnt[gi])
    );
  end

  assign w_int_en = r_mie_g & bus.int_ok;
  assign w_pend   = r_mie & r_mip;

  always_comb begin
    w_kind = TrapNone;
    w_code = '0;
    if (bus.exc_valid) begin
      w_kind = TrapExc;
      w_code = bus.exc_cause;
    end else if (w_int_en && w_pend[2]) begin
      w_kind = TrapInt;
      w_code = IntMei;
    end else if (w_int_en && w_pend[0]) begin
      w_kind = TrapInt;
      w_code = IntMsi;
    end else if (w_int_en && w_pend[1]) begin
      w_kind = TrapInt;
      w_code = IntMti;
    end
  end

  assign w_trap    = (w_kind != TrapNone);
  assign w_is_int  = (w_kind == TrapInt);
  assign w_do_mret = bus.mret_req & ~w_trap;

`ifdef CSR_VECTORED_EN
  assign w_mtvec_rd = {r_mtvec_base, 1'b0, r_mtvec_mode};
  assign w_vec = (r_mtvec_mode && w_is_int) ? {r_mtvec_base, 2'b00} + XLEN'({w_code, 2'b00})
                                            : {r_mtvec_base, 2'b00};
`else
  assign w_mtvec_rd = {r_mtvec_base, 2'b00};
  assign w_vec      = {r_mtvec_base, 2'b00};
`endif

  always_comb begin
    w_mstatus = '0;
    w_mstatus[MstatusMpp+1:MstatusMpp] = 2'b11;
    w_mstatus[MstatusMpie] = r_mpie;
    w_mstatus[MstatusMie]  = r_mie_g;
  end

  always_comb begin
    w_rdata = '0;
    w_hit   = 1'b1;
    case (bus.raddr)
      CsrMstatus:       w_rdata = w_mstatus;
      CsrMisa:          w_rdata = XLEN'(misa_value(XLEN));
      CsrMie: begin
        w_rdata[MieMeie] = r_mie[2];
        w_rdata[MieMtie] = r_mie[1];
        w_rdata[MieMsie] = r_mie[0];
      end
      CsrMip: begin
        w_rdata[MieMeie] = r_mip[2];
        w_rdata[MieMtie] = r_mip[1];
        w_rdata[MieMsie] = r_mip[0];
      end
      CsrMtvec:         w_rdata = w_mtvec_rd;
      CsrMscratch:      w_rdata = r_mscratch;
      CsrMepc:          w_rdata = r_mepc;
      CsrMcause:        w_rdata = {r_mcause_int, {(XLEN-6){1'b0}}, r_mcause_code};
      CsrMtval:         w_rdata = r_mtval;
      CsrMcountinhibit: w_rdata = XLEN'(r_inhibit);
      default: begin
        w_hit = 1'b0;
        for (int i = 0; i < NumCnt; i++) begin
          if (bus.raddr == CsrMcycle + 12'(counter_csr_num(i))) begin
            w_hit   = 1'b1;
            w_rdata = w_cnt[i][XLEN-1:0];
          end
          if ((XLEN == 32) && (bus.raddr == CsrMcycleh + 12'(counter_csr_num(i)))) begin
            w_hit   = 1'b1;
            w_rdata = XLEN'(w_cnt[i][63:32]);
          end
        end
      end
    endcase
  end

  // Trap/mret updates come last so they override a same-cycle CSR write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mie_g       <= 1'b0;
      r_mpie        <= 1'b0;
      r_mie         <= '0;
      r_mip         <= '0;
      r_mtvec_base  <= '0;
`ifdef CSR_VECTORED_EN
      r_mtvec_mode  <= 1'b0;
`endif
      r_mscratch    <= '0;
      r_mepc        <= '0;
      r_mtval       <= '0;
      r_mcause_int  <= 1'b0;
      r_mcause_code <= '0;
      r_inhibit     <= '0;
      r_trap        <= 1'b0;
      r_mret        <= 1'b0;
      r_trap_vec    <= '0;
    end else begin
      r_mip  <= {bus.meip, bus.mtip, bus.msip};
      r_trap <= w_trap;
      r_mret <= w_do_mret;
      if (bus.wren) begin
        case (bus.waddr)
          CsrMstatus: begin
            r_mie_g <= bus.wdata[MstatusMie];
            r_mpie  <= bus.wdata[MstatusMpie];
          end
          CsrMie:      r_mie <= {bus.wdata[MieMeie], bus.wdata[MieMtie], bus.wdata[MieMsie]};
          CsrMtvec: begin
            r_mtvec_base <= bus.wdata[XLEN-1:2];
`ifdef CSR_VECTORED_EN
            r_mtvec_mode <= (bus.wdata[1:0] == 2'b01);
`endif
          end
          CsrMscratch: r_mscratch <= bus.wdata;
          CsrMepc:     r_mepc <= bus.wdata & ~XLEN'(1);
          CsrMcause: begin
            r_mcause_int  <= bus.wdata[XLEN-1];
            r_mcause_code <= bus.wdata[4:0];
          end
          CsrMtval:         r_mtval <= bus.wdata;
          CsrMcountinhibit: r_inhibit <= bus.wdata[InhW-1:0] & InhMask;
          default: ;
        endcase
      end
      if (w_trap) begin
        r_mpie        <= r_mie_g;
        r_mie_g       <= 1'b0;
        r_mepc        <= (w_is_int ? bus.int_epc : bus.exc_epc) & ~XLEN'(1);
        r_mcause_int  <= w_is_int;
        r_mcause_code <= w_code;
        r_mtval       <= w_is_int ? '0 : bus.exc_tval;
        r_trap_vec    <= w_vec;
      end else if (w_do_mret) begin
        r_mie_g <= r_mpie;
        r_mpie  <= 1'b1;
      end
    end
  end

  assign bus.rdata    = w_rdata;
  assign bus.illegal  = bus.rden & ~w_hit;
  assign bus.trap     = r_trap;
  assign bus.mret     = r_mret;
  assign bus.trap_vec = r_trap_vec;
  assign bus.mepc_out = r_mepc;

endmodule

// File: tb/tb_csr_machine.sv
// Scoreboard bench for csr_machine: stimulus queues expectations, a monitor checks them.
module tb_csr_machine;
  import csr_pkg::*;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_HPM  = 4;
  localparam int unsigned RETIRE_W = 2;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        ill;
  } rd_exp_t;

  typedef struct {
    string       name;
    logic        is_trap;
    logic [31:0] vec;
    logic [31:0] epc;
  } ev_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_machine_if #(.XLEN(XLEN), .NUM_HPM(NUM_HPM), .RETIRE_W(RETIRE_W)) bus ();

  csr_machine #(.XLEN(XLEN), .NUM_HPM(NUM_HPM), .RETIRE_W(RETIRE_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  rd_exp_t rd_q[$];
  ev_exp_t ev_q[$];
  rd_exp_t mon_rd;
  ev_exp_t mon_ev;
  int n_checks = 0;
  int n_pass   = 0;

`ifdef CSR_VECTORED_EN
  localparam logic [31:0] MtvecRd = 32'h101;
  localparam logic [31:0] MtiVec  = 32'h11C;
`else
  localparam logic [31:0] MtvecRd = 32'h100;
  localparam logic [31:0] MtiVec  = 32'h100;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.wren  = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    tick();
    bus.wren  = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] exp,
                    input logic ill = 1'b0);
    bus.rden  = 1'b1;
    bus.raddr = a;
    rd_q.push_back('{name: nm, data: exp, ill: ill});
    tick();
    bus.rden  = 1'b0;
  endtask

  task automatic expect_ev(input string nm, input logic is_trap, input logic [31:0] vec,
                           input logic [31:0] epc);
    ev_q.push_back('{name: nm, is_trap: is_trap, vec: vec, epc: epc});
  endtask

  task automatic wait_ev(input string nm);
    for (int i = 0; i < 4 && ev_q.size() != 0; i++) tick();
    check({nm, "_drained"}, 64'(ev_q.size()), 64'd0);
  endtask

  // Monitor: reads whenever rden is high, events whenever a pulse is present.
  always @(negedge clk) begin
    if (bus.rden) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 64'd1, 64'd0);
      end else begin
        mon_rd = rd_q.pop_front();
        check({mon_rd.name, "_data"}, 64'(bus.rdata), 64'(mon_rd.data));
        check({mon_rd.name, "_illegal"}, 64'(bus.illegal), 64'(mon_rd.ill));
      end
    end
    if (bus.trap || bus.mret) begin
      if (ev_q.size() == 0) begin
        check("pulse_unexpected", 64'({bus.trap, bus.mret}), 64'd0);
      end else begin
        mon_ev = ev_q.pop_front();
        check({mon_ev.name, "_kind"}, 64'({bus.trap, bus.mret}),
              mon_ev.is_trap ? 64'd2 : 64'd1);
        if (mon_ev.is_trap) check({mon_ev.name, "_vec"}, 64'(bus.trap_vec), 64'(mon_ev.vec));
        check({mon_ev.name, "_epc"}, 64'(bus.mepc_out), 64'(mon_ev.epc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rden = 0; bus.raddr = 0; bus.wren = 0; bus.waddr = 0; bus.wdata = 0;
    bus.retire = 0; bus.hpm_event = 0; bus.exc_valid = 0; bus.exc_cause = 0;
    bus.exc_epc = 0; bus.exc_tval = 0; bus.int_epc = 0; bus.int_ok = 0;
    bus.mret_req = 0; bus.meip = 0; bus.mtip = 0; bus.msip = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    repeat (10) tick();
    rd("mcycle_10", CsrMcycle, 32'd10);
    rd("mstatus_rst", CsrMstatus, 32'h1800);
    rd("mie_rst", CsrMie, 32'h0);
    rd("mtvec_rst", CsrMtvec, 32'h0);
    rd("mcause_rst", CsrMcause, 32'h0);
    rd("minstret_rst", CsrMinstret, 32'h0);
    rd("unimpl", 12'h7C0, 32'h0, 1'b1);

    // MSI beats MTI
    wr(CsrMstatus, 32'h8);
    wr(CsrMie, 32'h888);
    bus.int_ok = 1; bus.int_epc = 32'h8000_0100; bus.msip = 1; bus.mtip = 1;
    expect_ev("trap_msi", 1'b1, 32'h0, 32'h8000_0100);
    tick();
    tick();
    bus.msip = 0; bus.mtip = 0; bus.int_ok = 0;
    wait_ev("trap_msi");
    rd("mcause_msi", CsrMcause, 32'h8000_0003);
    rd("mstatus_msi", CsrMstatus, 32'h1880);
    rd("mepc_msi", CsrMepc, 32'h8000_0100);
    rd("mtval_msi", CsrMtval, 32'h0);

    // mret restores MIE
    bus.mret_req = 1;
    expect_ev("mret", 1'b0, 32'h0, 32'h8000_0100);
    tick();
    bus.mret_req = 0;
    wait_ev("mret");
    rd("mstatus_mret", CsrMstatus, 32'h1888);

    // Exception beats pending MEI and a same-cycle mret
    wr(CsrMtvec, 32'h200);
    bus.meip = 1;
    tick();
    bus.exc_valid = 1; bus.exc_cause = ExcIllegalInstr; bus.exc_epc = 32'h8000_0204;
    bus.exc_tval = 32'hDEAD_BEEF; bus.int_ok = 1; bus.mret_req = 1;
    expect_ev("trap_exc", 1'b1, 32'h200, 32'h8000_0204);
    tick();
    bus.exc_valid = 0; bus.mret_req = 0; bus.int_ok = 0; bus.meip = 0;
    wait_ev("trap_exc");
    rd("mcause_exc", CsrMcause, 32'h2);
    rd("mepc_exc", CsrMepc, 32'h8000_0204);
    rd("mtval_exc", CsrMtval, 32'hDEAD_BEEF);
    rd("mstatus_exc", CsrMstatus, 32'h1880);

    // Plain register behaviour
    wr(CsrMepc, 32'h1235);
    rd("mepc_bit0", CsrMepc, 32'h1234);
    wr(CsrMscratch, 32'hA5A5_5A5A);
    rd("mscratch", CsrMscratch, 32'hA5A5_5A5A);
    wr(CsrMip, 32'h888);
    rd("mip_ro", CsrMip, 32'h0);

    // mcycle carry into high half
    wr(CsrMcycle, 32'hFFFF_FFFF);
    tick();
    rd("mcycle_wrap_lo", CsrMcycle, 32'h0);
    rd("mcycle_wrap_hi", CsrMcycleh, 32'h1);

    // mcountinhibit hardwired bits and inhibit of mcycle
    wr(CsrMcountinhibit, 32'hFFFF_FFFF);
    rd("minhibit_mask", CsrMcountinhibit, 32'h7D);
    wr(CsrMcycle, 32'd5);
    rd("mcycle_inh_a", CsrMcycle, 32'd5);
    rd("mcycle_inh_b", CsrMcycle, 32'd5);

    // minstret inhibit, multi-retire, half write, write-beats-increment
    wr(CsrMcountinhibit, 32'h4);
    bus.retire = 2;
    repeat (5) tick();
    bus.retire = 0;
    rd("minstret_inh", CsrMinstret, 32'd0);
    wr(CsrMcountinhibit, 32'h0);
    bus.retire = 2;
    repeat (3) tick();
    bus.retire = 0;
    rd("minstret_6", CsrMinstret, 32'd6);
    wr(CsrMinstreth, 32'h12);
    rd("minstreth", CsrMinstreth, 32'h12);
    rd("minstret_keep", CsrMinstret, 32'd6);
    bus.retire = 2;
    wr(CsrMinstret, 32'd100);
    bus.retire = 0;
    rd("minstret_wr", CsrMinstret, 32'd100);

    // HPM counters
    bus.hpm_event = 4'b0101;
    repeat (3) tick();
    bus.hpm_event = 4'b0000;
    rd("hpm3", CsrMhpm3, 32'd3);
    rd("hpm4", CsrMhpm3 + 12'd1, 32'd0);
    rd("hpm5", CsrMhpm3 + 12'd2, 32'd3);
    rd("hpm6h", CsrMhpm3h + 12'd3, 32'd0);
    rd("hpm7_unimpl", CsrMhpm3 + 12'd4, 32'd0, 1'b1);

    // MTI with mtvec mode bit requested
    wr(CsrMstatus, 32'h8);
    wr(CsrMie, 32'h80);
    wr(CsrMtvec, 32'h101);
    rd("mtvec_warl", CsrMtvec, MtvecRd);
    bus.mtip = 1; bus.int_ok = 1; bus.int_epc = 32'h3000;
    expect_ev("trap_mti", 1'b1, MtiVec, 32'h3000);
    tick();
    tick();
    bus.mtip = 0; bus.int_ok = 0;
    wait_ev("trap_mti");
    rd("mcause_mti", CsrMcause, 32'h8000_0007);

    // Reset kills a pending trap
    bus.exc_valid = 1; bus.exc_cause = ExcBreakpoint;
    rst = 1'b1;
    tick();
    check("rst_kills_trap", 64'(bus.trap), 64'd0);
    bus.exc_valid = 0;
    tick();
    rst = 1'b0;
    rd("mstatus_rst2", CsrMstatus, 32'h1800);
    rd("mtvec_rst2", CsrMtvec, 32'h0);
    rd("minstret_rst2", CsrMinstret, 32'h0);

    tick();
    tick();
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
    check("ev_q_empty", 64'(ev_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
